// File: rtl/ss_fifo_burst_reader.sv
// Read-side burst controller for the threshold FIFO: credit-limited reads into a 2-entry skid buffer, valid/ready out.
// Optional macro SS_FIFO_RD_LAST_EN adds a per-word last tag driving m_last.
module ss_fifo_burst_reader #(
    parameter int Bw_d  = 8,
    parameter int Bw_a  = 10,
    parameter int Burst = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_rd_rdy,
    output logic            fifo_rd_en,
    input  logic [Bw_d-1:0] fifo_rd_do,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [Bw_d-1:0] m_data,
    output logic            m_last,
    input  logic            flush_req,
    input  logic [Bw_a:0]   flush_len,
    output logic            flush_done,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    logic [1:0]      state;
    logic [Bw_a:0]   rem;
    logic            pend;
    logic [Bw_a:0]   pend_len;
    logic            is_flush;
    logic            inflight;
    logic [Bw_d-1:0] buf_data [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      cnt;

    logic            pop;
    logic            credit_ok;
    logic            last_pop;
    logic [2:0]      occ;

    assign dbg_state = state;
    assign m_valid   = (cnt != 2'd0);
    assign m_data    = buf_data[rd_ptr];
    assign pop       = m_valid & m_ready;
    assign busy      = (state != IDLE) || (cnt != 2'd0);

    // A word popped this cycle frees its slot for a read issued this cycle.
    assign occ        = {1'b0, cnt} + {2'b00, inflight};
    assign credit_ok  = occ < (3'd2 + {2'b00, pop});
    assign fifo_rd_en = !reset && ((state == BURST) || (state == FLUSH)) &&
                        (rem != '0) && credit_ok;

    // Transfers never overlap, so the final word is the only one left anywhere.
    assign last_pop   = pop && (cnt == 2'd1) && !inflight;
    assign flush_done = ((state == WAIT) && is_flush && last_pop) ||
                        ((state == FLUSH) && (rem == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rem         <= '0;
            pend        <= 1'b0;
            pend_len    <= '0;
            is_flush    <= 1'b0;
            inflight    <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            cnt         <= 2'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight) begin
                buf_data[wr_ptr] <= fifo_rd_do;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, inflight} - {1'b0, pop};

            if (flush_req && (state != IDLE) && !pend) begin
                pend     <= 1'b1;
                pend_len <= flush_len;
            end

            case (state)
                IDLE: begin
                    if (pend) begin
                        state    <= FLUSH;
                        rem      <= pend_len;
                        pend     <= 1'b0;
                        is_flush <= 1'b1;
                    end else if (flush_req) begin
                        state    <= FLUSH;
                        rem      <= flush_len;
                        is_flush <= 1'b1;
                    end else if (fifo_rd_rdy) begin
                        state    <= BURST;
                        rem      <= (Bw_a + 1)'(Burst);
                        is_flush <= 1'b0;
                    end
                end
                BURST, FLUSH: begin
                    if (fifo_rd_en) begin
                        rem <= rem - (Bw_a + 1)'(1);
                        if (rem == (Bw_a + 1)'(1)) state <= WAIT;
                    end else if (rem == '0) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (last_pop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SS_FIFO_RD_LAST_EN
    logic       inflight_last;
    logic [1:0] buf_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_last <= 1'b0;
            buf_last      <= 2'b00;
        end else begin
            inflight_last <= fifo_rd_en && (rem == (Bw_a + 1)'(1));
            if (inflight) buf_last[wr_ptr] <= inflight_last;
        end
    end

    assign m_last = m_valid & buf_last[rd_ptr];
`else
    assign m_last = 1'b0;
`endif

endmodule
